// File: rtl/uc_sequenciador_canais.sv
// rtl/uc_sequenciador_canais.sv - game-tick sequencer running compare/move handshakes over N entity channels
// Moore FSM with registered pulse outputs, channel enable mask, handshake watchdog and frame counter.
module uc_sequenciador_canais #(
  parameter int N_CANAIS = 2,
  parameter int CW       = 3,
  parameter int TIMEOUT  = 1023,
  parameter int TW       = 10,
  parameter int QW       = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tick,
  input  logic                forca_tick,
  input  logic                pede_gera,
  input  logic                fim_gera,
  input  logic [N_CANAIS-1:0] habilita_canal,
  input  logic [N_CANAIS-1:0] tem_mais,
  input  logic [N_CANAIS-1:0] fim_compara,
  input  logic [N_CANAIS-1:0] fim_move,
  input  logic                fim_frame,
  output logic [N_CANAIS-1:0] compara,
  output logic [N_CANAIS-1:0] move,
  output logic                gera_asteroide,
  output logic                reset_gerador_random,
  output logic                gera_frame,
  output logic                pausar_renderizacao,
  output logic                fim_ciclo,
  output logic                erro_timeout,
  output logic [QW-1:0]       contador_quadros,
  output logic [CW-1:0]       db_canal,
  output logic [4:0]          db_estado
);

  typedef enum logic [4:0] {
    INICIO         = 5'd0,
    INICIA_GERA    = 5'd1,
    ESPERA_GERA    = 5'd2,
    ESPERA         = 5'd3,
    SELECIONA      = 5'd4,
    COMPARA        = 5'd5,
    ESPERA_COMPARA = 5'd6,
    MOVE           = 5'd7,
    ESPERA_MOVE    = 5'd8,
    INICIA_FRAME   = 5'd9,
    ESPERA_FRAME   = 5'd10,
    FIM            = 5'd11,
    ERRO           = 5'd12
  } estado_t;

  estado_t             estado, prox;
  logic [CW-1:0]       canal, prox_canal;
  logic [TW-1:0]       wd;
  logic [TW:0]         wd_inc;
  logic [N_CANAIS-1:0] sel, prox_sel;
  logic                esperando, pronto, estouro;

  // One-hot channel decode avoids indexing the vectors with canal == N_CANAIS.
  always_comb begin
    sel      = '0;
    prox_sel = '0;
    for (int i = 0; i < N_CANAIS; i++) begin
      sel[i]      = (canal == CW'(i));
      prox_sel[i] = (prox_canal == CW'(i));
    end
  end

  always_comb begin
    esperando = 1'b0;
    pronto    = 1'b0;
    case (estado)
      ESPERA_GERA:    begin esperando = 1'b1; pronto = fim_gera; end
      ESPERA_COMPARA: begin esperando = 1'b1; pronto = |(fim_compara & sel); end
      ESPERA_MOVE:    begin esperando = 1'b1; pronto = |(fim_move & sel); end
      ESPERA_FRAME:   begin esperando = 1'b1; pronto = fim_frame; end
      default:        ;
    endcase
  end

  // Timeout fires on the wait cycle whose increment would reach TIMEOUT.
  assign wd_inc  = {1'b0, wd} + (TW+1)'(1);
  assign estouro = esperando && !pronto && (TIMEOUT != 0) && (wd_inc == (TW+1)'(TIMEOUT));

  always_comb begin
    prox       = estado;
    prox_canal = canal;
    case (estado)
      INICIO:      prox = INICIA_GERA;
      INICIA_GERA: prox = ESPERA_GERA;
      ESPERA_GERA: begin
        if (pronto)       prox = ESPERA;
        else if (estouro) prox = ERRO;
      end
      ESPERA: begin
        if (pede_gera) begin
          prox = INICIA_GERA;
        end else if (tick || forca_tick) begin
          prox       = SELECIONA;
          prox_canal = '0;
        end
      end
      SELECIONA: begin
        if (canal == CW'(N_CANAIS))        prox = INICIA_FRAME;
        else if (|(habilita_canal & sel)) prox = COMPARA;
        else                               prox_canal = canal + CW'(1);
      end
      COMPARA: prox = ESPERA_COMPARA;
      ESPERA_COMPARA: begin
        if (pronto) begin
          if (|(tem_mais & sel)) begin
            prox = MOVE;
          end else begin
            prox       = SELECIONA;
            prox_canal = canal + CW'(1);
          end
        end else if (estouro) begin
          prox = ERRO;
        end
      end
      MOVE: prox = ESPERA_MOVE;
      ESPERA_MOVE: begin
        if (pronto)       prox = COMPARA;
        else if (estouro) prox = ERRO;
      end
      INICIA_FRAME: prox = ESPERA_FRAME;
      ESPERA_FRAME: begin
        if (pronto)       prox = FIM;
        else if (estouro) prox = ERRO;
      end
      FIM:     prox = ESPERA;
      ERRO:    prox = ERRO;
      default: prox = INICIO;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado               <= INICIO;
      canal                <= '0;
      wd                   <= '0;
      contador_quadros     <= '0;
      compara              <= '0;
      move                 <= '0;
      gera_asteroide       <= 1'b0;
      reset_gerador_random <= 1'b1;
      gera_frame           <= 1'b0;
      pausar_renderizacao  <= 1'b0;
      fim_ciclo            <= 1'b0;
      erro_timeout         <= 1'b0;
    end else begin
      estado <= prox;
      canal  <= prox_canal;
      if (prox != estado)             wd <= '0;
      else if (esperando && !pronto)  wd <= wd + TW'(1);
      if (estado == FIM) contador_quadros <= contador_quadros + QW'(1);
      compara              <= (prox == COMPARA) ? prox_sel : '0;
      move                 <= (prox == MOVE) ? prox_sel : '0;
      gera_asteroide       <= (prox == INICIA_GERA);
      reset_gerador_random <= (prox == INICIO);
      gera_frame           <= (prox == INICIA_FRAME);
      pausar_renderizacao  <= (prox == INICIA_FRAME) || (prox == ESPERA_FRAME);
      fim_ciclo            <= (prox == FIM);
      erro_timeout         <= (prox == ERRO);
    end
  end

  assign db_canal  = canal;
  assign db_estado = (5'(estado) <= 5'd12) ? 5'(estado) : 5'd31;

endmodule
